alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have parameter OP_LW, default 7'b0000011, meaning the load opcode.
REQ-002 The module SHALL have parameter OP_SW, default 7'b0100011, meaning the store opcode.
REQ-003 The module SHALL have parameter OP_R, default 7'b0110011, meaning the register ALU opcode.
REQ-004 The module SHALL have parameter OP_I, default 7'b0010011, meaning the immediate ALU opcode.
REQ-005 The module SHALL have parameter OP_BEQ, default 7'b1100011, meaning the branch-equal opcode.
REQ-006 The module SHALL have a single clock; reset SHALL be synchronous and active-high.
REQ-007 The module SHALL have these ports; each line gives name, direction, width and meaning:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- opcode  in  7  instruction[6:0], sampled from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- ALUOP  out  3  ALU operation category: 000 add, 001 sub, 111 funct3-decoded.
- ALUSrcA  out  2  operand A select: 00 PC, 01 OldPC, 10 rs1.
- ALUSrcB  out  2  operand B select: 00 rs2, 01 immediate, 10 constant 4.
- ResultSrc  out  2  result select: 00 ALUOut, 01 memory data, 10 ALU direct.
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut.
- IRWrite  out  1  instruction register load enable.
- PCWrite  out  1  PC load enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.
- state  out  4  current FSM state, for debug.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
- instret  out  32  count of retired instructions.

Function
REQ-008 The FSM SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9.
REQ-009 In FETCH, the outputs SHALL be AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOP=000, ResultSrc=10, and IRWrite=PCWrite=mem_ready.
REQ-010 FETCH SHALL remain in FETCH while mem_ready=0 and SHALL go to DECODE when mem_ready=1.
REQ-011 In DECODE, the outputs SHALL be ALUSrcA=01, ALUSrcB=01, ALUOP=000 (branch target into ALUOut).
REQ-012 From DECODE, the next state SHALL be:
- lw or sw -> MEMADR.
- R -> EXECR.
- I -> EXECI.
- beq -> BEQ.
- any other opcode -> FETCH, with illegal_op pulsed for that DECODE cycle and no instret increment.
REQ-013 In MEMADR, the outputs SHALL be ALUSrcA=10, ALUSrcB=01, ALUOP=000; the next state SHALL be MEMREAD for lw and MEMWRITE for sw.
REQ-014 In MEMREAD, the outputs SHALL be AdrSrc=1, ResultSrc=00; the FSM SHALL hold until mem_ready=1, then go to MEMWB.
REQ-015 In MEMWB, the outputs SHALL be ResultSrc=01, RegWrite=1; the next state SHALL be FETCH.
REQ-016 In MEMWRITE, the outputs SHALL be AdrSrc=1, ResultSrc=00, MemWrite=1, held until mem_ready=1; the next state SHALL then be FETCH.
REQ-017 In EXECR, the outputs SHALL be ALUSrcA=10, ALUSrcB=00, ALUOP=111; in EXECI, ALUSrcA=10, ALUSrcB=01, ALUOP=111; both SHALL go to ALUWB.
REQ-018 In ALUWB, the outputs SHALL be ResultSrc=00, RegWrite=1; the next state SHALL be FETCH.
REQ-019 In BEQ, the outputs SHALL be ALUSrcA=10, ALUSrcB=00, ALUOP=001, ResultSrc=00, PCWrite=zero; the next state SHALL be FETCH.
REQ-020 Any output not listed for a state SHALL be 0; undefined state encodings SHALL go to FETCH.
REQ-021 opcode SHALL be sampled only in DECODE and MEMADR.
REQ-022 instr_done SHALL pulse on the final cycle of MEMWB, MEMWRITE (when mem_ready=1), ALUWB and BEQ.
REQ-023 instret SHALL increment by 1 on the clock edge following each instr_done pulse and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-024 Instruction latency SHALL be: lw 5 cycles, sw 4 cycles, R/I 4 cycles, beq 3 cycles, each excluding mem_ready stall cycles.

Reset
REQ-025 While rst=1 at a clock edge, the module SHALL set state to FETCH and instret to 0.
REQ-026 While rst=1, IRWrite, PCWrite, RegWrite, MemWrite, instr_done and illegal_op SHALL be forced to 0 regardless of state or mem_ready.
REQ-027 Reset asserted mid-instruction (including during a MEMWRITE stall) SHALL abort the instruction with no further write strobes and no instret increment.

Verification
REQ-028 The bench SHALL cover: rst for 2 cycles, mem_ready=1, opcode=OP_R -> state sequence 0,1,6,8,0; RegWrite high only in state 8; instret=1.
REQ-029 The bench SHALL cover: opcode=OP_LW, mem_ready=0 for 3 cycles in MEMREAD -> state stays 3 for 3 cycles, 5 productive cycles total, ResultSrc=01 in MEMWB.
REQ-030 The bench SHALL cover: opcode=OP_BEQ with zero=1 and then with zero=0 -> PCWrite=1 in BEQ for the first and PCWrite=0 for the second; both take 3 cycles.
REQ-031 The bench SHALL cover: opcode=7'b1111111 -> illegal_op pulses in DECODE, return to FETCH, instret unchanged.
REQ-032 The bench SHALL cover: rst asserted during MEMWRITE with mem_ready=0 -> MemWrite=0 that cycle, state=0 next, instret=0.
REQ-033 The bench SHALL cover: instret forced near 32'hFFFFFFFF, then two ALU instructions retired -> instret wraps to 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multicycle RISC-V style control sequencer: a ten-state FSM that steps
// lw/sw/R/I/beq instructions, drives datapath selects and strobes, and counts retirements.
module alu_sequencer #(
  parameter logic [6:0] OP_LW  = 7'b0000011,
  parameter logic [6:0] OP_SW  = 7'b0100011,
  parameter logic [6:0] OP_R   = 7'b0110011,
  parameter logic [6:0] OP_I   = 7'b0010011,
  parameter logic [6:0] OP_BEQ = 7'b1100011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  ALUOP,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instret_q;
  logic        irw, pcw, rw, mw, done, ill;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (done) instret_q <= instret_q + 32'd1;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path through the block can leave a latch behind.
  always_comb begin
    state_d   = S_FETCH;
    ALUOP     = 3'b000;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    irw       = 1'b0;
    pcw       = 1'b0;
    rw        = 1'b0;
    mw        = 1'b0;
    done      = 1'b0;
    ill       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = mem_ready;
        pcw       = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_R)                state_d = S_EXECR;
        else if (opcode == OP_I)                state_d = S_EXECI;
        else if (opcode == OP_BEQ)              state_d = S_BEQ;
        else                                    ill     = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        done      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc  = 1'b1;
        mw      = 1'b1;
        done    = mem_ready;
        state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOP   = 3'b111;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOP   = 3'b111;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw   = 1'b1;
        done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOP   = 3'b001;
        pcw     = zero;
        done    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset overrides every strobe so an aborted instruction writes nothing.
  assign IRWrite    = irw  & ~rst;
  assign PCWrite    = pcw  & ~rst;
  assign RegWrite   = rw   & ~rst;
  assign MemWrite   = mw   & ~rst;
  assign instr_done = done & ~rst;
  assign illegal_op = ill  & ~rst;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: per-instruction cycle profiles are
// expanded into expected per-cycle records and compared against the DUT.
module tb_alu_sequencer;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst, zero, mem_ready;
  logic [6:0]  opcode;
  logic [2:0]  ALUOP;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic        AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
  logic [3:0]  state;
  logic        instr_done, illegal_op;
  logic [31:0] instret;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUOP(ALUOP), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aluop;
    logic [1:0] srca, srcb, res;
    logic       adr, irw, pcw, rw, mw, done, ill;
  } obs_t;

  typedef struct packed {
    obs_t e;
    logic mr;     // mem_ready to drive
    logic mr_dc;  // mem_ready irrelevant: drive random
    logic samp;   // opcode is sampled this cycle: drive the real one
  } step_t;

  step_t       q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_instret;

  function automatic obs_t observed();
    obs_t o;
    o = {state, ALUOP, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
         IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_op};
    return o;
  endfunction

  // Datapath selects listed for each state; anything unlisted is zero.
  function automatic obs_t base(input logic [3:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0: begin e.srcb = 2'b10; e.res = 2'b10; end
      4'd1: begin e.srca = 2'b01; e.srcb = 2'b01; end
      4'd2: begin e.srca = 2'b10; e.srcb = 2'b01; end
      4'd3: e.adr = 1'b1;
      4'd4: e.res = 2'b01;
      4'd5: e.adr = 1'b1;
      4'd6: begin e.srca = 2'b10; e.aluop = 3'b111; end
      4'd7: begin e.srca = 2'b10; e.srcb = 2'b01; e.aluop = 3'b111; end
      4'd9: begin e.srca = 2'b10; e.aluop = 3'b001; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input obs_t o, input obs_t e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s instret observed=%h expected=%h", tag, o, e);
    end
  endtask

  // strobes = {IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_op}
  task automatic push(input logic [3:0] st, input logic mr, input logic dc,
                      input logic samp, input logic [5:0] strobes);
    step_t s;
    s.e = base(st);
    {s.e.irw, s.e.pcw, s.e.rw, s.e.mw, s.e.done, s.e.ill} = strobes;
    s.mr = mr;
    s.mr_dc = dc;
    s.samp = samp;
    q.push_back(s);
  endtask

  // Expand one instruction into its expected cycle profile.
  task automatic build(input logic [6:0] op, input logic z, input int sf, input int sm);
    q.delete();
    repeat (sf) push(4'd0, 1'b0, 1'b0, 1'b0, 6'b000000);
    push(4'd0, 1'b1, 1'b0, 1'b0, 6'b110000);
    if (op == OP_LW) begin
      push(4'd1, 1'b0, 1'b1, 1'b1, 6'b000000);
      push(4'd2, 1'b0, 1'b1, 1'b1, 6'b000000);
      repeat (sm) push(4'd3, 1'b0, 1'b0, 1'b0, 6'b000000);
      push(4'd3, 1'b1, 1'b0, 1'b0, 6'b000000);
      push(4'd4, 1'b0, 1'b1, 1'b0, 6'b001010);
    end else if (op == OP_SW) begin
      push(4'd1, 1'b0, 1'b1, 1'b1, 6'b000000);
      push(4'd2, 1'b0, 1'b1, 1'b1, 6'b000000);
      repeat (sm) push(4'd5, 1'b0, 1'b0, 1'b0, 6'b000100);
      push(4'd5, 1'b1, 1'b0, 1'b0, 6'b000110);
    end else if (op == OP_R || op == OP_I) begin
      push(4'd1, 1'b0, 1'b1, 1'b1, 6'b000000);
      push((op == OP_R) ? 4'd6 : 4'd7, 1'b0, 1'b1, 1'b0, 6'b000000);
      push(4'd8, 1'b0, 1'b1, 1'b0, 6'b001010);
    end else if (op == OP_BEQ) begin
      push(4'd1, 1'b0, 1'b1, 1'b1, 6'b000000);
      push(4'd9, 1'b0, 1'b1, 1'b0, {1'b0, z, 4'b0010});
    end else begin
      push(4'd1, 1'b0, 1'b1, 1'b1, 6'b000001);
    end
  endtask

  // Opcode is garbage outside its sampling cycles to catch stray decoding.
  task automatic drive_queue(input logic [6:0] op, input logic z, input string tag);
    foreach (q[i]) begin
      @(posedge clk);
      #1;
      rst       = 1'b0;
      opcode    = q[i].samp ? op : 7'($urandom);
      mem_ready = q[i].mr_dc ? 1'($urandom) : q[i].mr;
      zero      = z;
      #1;
      check($sformatf("%s[%0d]", tag, i), observed(), q[i].e);
      check_cnt($sformatf("%s[%0d]", tag, i), instret, model_instret);
      if (q[i].e.done) model_instret = model_instret + 32'd1;
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic z, input int sf,
                           input int sm, input string tag);
    build(op, z, sf, sm);
    drive_queue(op, z, tag);
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] op;
    obs_t       e;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_BAD};
    rst = 1'b1; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
    model_instret = '0;

    // Two reset cycles with mem_ready high: strobes must stay low.
    repeat (2) begin
      @(posedge clk);
      #1 mem_ready = 1'b1;
      #1 check("reset", observed(), base(4'd0));
      check_cnt("reset", instret, model_instret);
    end
    rst = 1'b0;
    mem_ready = 1'b0;

    run_instr(OP_R,   1'b0, 0, 0, "r_basic");
    run_instr(OP_LW,  1'b0, 0, 3, "lw_stall3");
    run_instr(OP_BEQ, 1'b1, 0, 0, "beq_taken");
    run_instr(OP_BEQ, 1'b0, 0, 0, "beq_not_taken");
    run_instr(OP_BAD, 1'b0, 0, 0, "illegal");
    run_instr(OP_SW,  1'b0, 1, 2, "sw_stall2");
    run_instr(OP_I,   1'b0, 2, 0, "i_fetch_stall");

    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 5)];
      if (op == OP_BAD) op = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b0110111;
      run_instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                $sformatf("rand%0d", k));
    end

    // Reset during a stalled store: strobes drop at once, count clears.
    q.delete();
    push(4'd0, 1'b1, 1'b0, 1'b0, 6'b110000);
    push(4'd1, 1'b0, 1'b1, 1'b1, 6'b000000);
    push(4'd2, 1'b0, 1'b1, 1'b1, 6'b000000);
    push(4'd5, 1'b0, 1'b0, 1'b0, 6'b000100);
    push(4'd5, 1'b0, 1'b0, 1'b0, 6'b000100);
    drive_queue(OP_SW, 1'b0, "sw_abort");
    @(posedge clk);
    #1 rst = 1'b1; mem_ready = 1'b0;
    #1 check("rst_in_memwrite", observed(), base(4'd5));
    @(posedge clk);
    #1 rst = 1'b0; mem_ready = 1'b0;
    model_instret = '0;
    #1 check("after_abort", observed(), base(4'd0));
    check_cnt("after_abort", instret, model_instret);

    // Preload the counter just below wrap, then retire two ALU ops.
    @(posedge clk);
    #1 mem_ready = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFE;
    #1 release dut.instret_q;
    model_instret = 32'hFFFF_FFFE;
    check_cnt("preload", instret, model_instret);
    run_instr(OP_R, 1'b0, 0, 0, "wrap_r");
    run_instr(OP_I, 1'b0, 0, 0, "wrap_i");
    @(posedge clk);
    #1 mem_ready = 1'b0;
    #1 check("wrap_idle", observed(), base(4'd0));
    check_cnt("wrap", instret, 32'h0000_0000);
    check_cnt("wrap_model", instret, model_instret);

    e = base(4'd0);
    check("final_idle", observed(), e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
